// File: rtl/counter_pkg.sv
// Shared definitions for the up/down counter: direction encoding and the
// elaboration-time legality check for WIDTH/MODULUS.
package counter_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    function automatic bit params_legal(input int width, input longint unsigned modulus);
        if (width < 1 || width > 32) begin
            return 1'b0;
        end
        return (modulus >= 64'd2) && (modulus <= (64'd1 << width));
    endfunction

endpackage

// File: rtl/updown_next_value.sv
// Combinational step logic: next count and terminal-count flag for the
// current count and direction. Arithmetic is done one bit wider than count.
module updown_next_value
    import counter_pkg::*;
#(
    parameter int                WIDTH   = 4,
    parameter longint unsigned   MODULUS = 64'd1 << WIDTH
) (
    input  logic [WIDTH-1:0] i_count,
    input  logic             i_up,
    output logic [WIDTH-1:0] o_next,
    output logic             o_tc
);

    localparam logic [WIDTH:0] LAST = (WIDTH+1)'(MODULUS - 64'd1);

    logic [WIDTH:0] w_ext;
    logic [WIDTH:0] w_sum;
    logic           w_tc;

    // The final clamp keeps an out-of-range count from ever propagating.
    always_comb begin
        w_ext = {1'b0, i_count};
        if (i_up == DIR_UP) begin
            w_tc  = (w_ext == LAST);
            w_sum = w_tc ? '0 : w_ext + 1'b1;
        end else begin
            w_tc  = (w_ext == '0);
            w_sum = w_tc ? LAST : w_ext - 1'b1;
        end
        o_next = (w_sum <= LAST) ? w_sum[WIDTH-1:0] : LAST[WIDTH-1:0];
    end

    assign o_tc = w_tc;

endmodule

// File: rtl/sync_updown_counter.sv
// Modulo-N up/down counter with clear, range-checked load, one-shot stop
// and wrap/done/load-error status; all state lives here.
module sync_updown_counter
    import counter_pkg::*;
#(
    parameter int              WIDTH   = 4,
    parameter longint unsigned MODULUS = 64'd1 << WIDTH
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    input  logic             up,
    input  logic             one_shot,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap,
    output logic             done,
    output logic             load_err
);

    localparam logic [WIDTH:0] LAST = (WIDTH+1)'(MODULUS - 64'd1);

    if (!params_legal(WIDTH, MODULUS)) begin : g_bad_params
        $fatal(1, "sync_updown_counter: illegal WIDTH/MODULUS combination");
    end

    logic [WIDTH-1:0] r_count;
    logic             r_wrap;
    logic             r_done;
    logic             r_loadErr;
    logic [WIDTH-1:0] w_next;
    logic             w_tc;
    logic             w_loadOver;

    updown_next_value #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
    ) u_next (
        .i_count (r_count),
        .i_up    (up),
        .o_next  (w_next),
        .o_tc    (w_tc)
    );

    assign w_loadOver = ({1'b0, load_value} > LAST);

    // A finished one-shot holds even if direction flips away from terminal.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count   <= '0;
            r_wrap    <= 1'b0;
            r_done    <= 1'b0;
            r_loadErr <= 1'b0;
        end else begin
            r_wrap    <= 1'b0;
            r_loadErr <= 1'b0;
            if (clear) begin
                r_count <= '0;
                r_done  <= 1'b0;
            end else if (load) begin
                r_done <= 1'b0;
                if (w_loadOver) begin
                    r_count   <= LAST[WIDTH-1:0];
                    r_loadErr <= 1'b1;
                end else begin
                    r_count <= load_value;
                end
            end else if (enable && !(r_done && one_shot)) begin
                if (w_tc && one_shot) begin
                    r_done <= 1'b1;
                end else begin
                    r_count <= w_next;
                    r_wrap  <= w_tc;
                end
            end
        end
    end

    assign count    = r_count;
    assign tc       = w_tc;
    assign wrap     = r_wrap;
    assign done     = r_done;
    assign load_err = r_loadErr;

endmodule

// File: tb/tb_sync_updown_counter.sv
// Self-checking bench for sync_updown_counter (WIDTH=4, MODULUS=10) using an
// expected-value queue filled as each cycle is driven.
module tb_sync_updown_counter;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       clear = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_value = '0;
    logic       enable = 1'b0;
    logic       up = 1'b1;
    logic       one_shot = 1'b0;
    logic [3:0] count;
    logic       tc;
    logic       wrap;
    logic       done;
    logic       load_err;

    typedef struct packed {
        logic [3:0] count;
        logic       tc;
        logic       wrap;
        logic       done;
        logic       loadErr;
    } exp_t;

    exp_t expQ[$];
    exp_t e;
    exp_t got;
    int   errors = 0;
    int   checks = 0;

    sync_updown_counter #(.WIDTH(4), .MODULUS(10)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .clear      (clear),
        .load       (load),
        .load_value (load_value),
        .enable     (enable),
        .up         (up),
        .one_shot   (one_shot),
        .count      (count),
        .tc         (tc),
        .wrap       (wrap),
        .done       (done),
        .load_err   (load_err)
    );

    always #5 clock = ~clock;

    task automatic test_reset();
        up = 1'b1;
        #1;
        checks++;
        if ({count, tc, wrap, done, load_err} !== 8'b0000_0000) begin
            errors++;
            $display("[TB] FAIL reset_up: got {count,tc,wrap,done,err}=%b want 00000000",
                     {count, tc, wrap, done, load_err});
        end
        up = 1'b0;
        #1;
        checks++;
        if (tc !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_tc_down: got tc=%b want 1", tc);
        end
        up = 1'b1;
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_count_up();
        enable = 1'b1; up = 1'b1; one_shot = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            expQ.push_back({4'(k % 10), 1'(k % 10 == 9), 1'(k == 10), 1'b0, 1'b0});
            @(posedge clock); #1;
            got = {count, tc, wrap, done, load_err};
            e = expQ.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("[TB] FAIL up_step%0d: got {count,tc,wrap,done,err}=%b want %b", k, got, e);
            end
        end
    endtask

    task automatic test_count_down();
        int dn[5] = '{2, 1, 0, 9, 8};
        load = 1'b1; load_value = 4'd3; enable = 1'b1; up = 1'b0;
        expQ.push_back({4'd3, 1'b0, 1'b0, 1'b0, 1'b0});
        @(posedge clock); #1;
        got = {count, tc, wrap, done, load_err};
        e = expQ.pop_front();
        checks++;
        if (got !== e) begin
            errors++;
            $display("[TB] FAIL down_load3: got {count,tc,wrap,done,err}=%b want %b", got, e);
        end
        load = 1'b0;
        for (int k = 0; k < 5; k++) begin
            expQ.push_back({4'(dn[k]), 1'(dn[k] == 0), 1'(k == 3), 1'b0, 1'b0});
            @(posedge clock); #1;
            got = {count, tc, wrap, done, load_err};
            e = expQ.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("[TB] FAIL down_step%0d: got {count,tc,wrap,done,err}=%b want %b", k, got, e);
            end
        end
    endtask

    task automatic test_one_shot();
        int os[4] = '{8, 9, 9, 9};
        one_shot = 1'b1; up = 1'b1; enable = 1'b0;
        load = 1'b1; load_value = 4'd7;
        expQ.push_back({4'd7, 1'b0, 1'b0, 1'b0, 1'b0});
        @(posedge clock); #1;
        got = {count, tc, wrap, done, load_err};
        e = expQ.pop_front();
        checks++;
        if (got !== e) begin
            errors++;
            $display("[TB] FAIL os_load7: got {count,tc,wrap,done,err}=%b want %b", got, e);
        end
        load = 1'b0; enable = 1'b1;
        for (int k = 0; k < 4; k++) begin
            expQ.push_back({4'(os[k]), 1'(os[k] == 9), 1'b0, 1'(k >= 2), 1'b0});
            @(posedge clock); #1;
            got = {count, tc, wrap, done, load_err};
            e = expQ.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("[TB] FAIL os_step%0d: got {count,tc,wrap,done,err}=%b want %b", k, got, e);
            end
        end
        // Direction flip while done: count must not move.
        up = 1'b0;
        expQ.push_back({4'd9, 1'b0, 1'b0, 1'b1, 1'b0});
        @(posedge clock); #1;
        got = {count, tc, wrap, done, load_err};
        e = expQ.pop_front();
        checks++;
        if (got !== e) begin
            errors++;
            $display("[TB] FAIL os_done_hold: got {count,tc,wrap,done,err}=%b want %b", got, e);
        end
        // Leaving one-shot mode resumes counting with done still set.
        up = 1'b1; one_shot = 1'b0;
        expQ.push_back({4'd0, 1'b0, 1'b1, 1'b1, 1'b0});
        @(posedge clock); #1;
        got = {count, tc, wrap, done, load_err};
        e = expQ.pop_front();
        checks++;
        if (got !== e) begin
            errors++;
            $display("[TB] FAIL os_resume: got {count,tc,wrap,done,err}=%b want %b", got, e);
        end
        enable = 1'b0;
    endtask

    task automatic test_load_err();
        string nm[4] = '{"lerr_load12", "lerr_idle", "lerr_load_over_step", "lerr_clear_prio"};
        logic [3:0] lv[4] = '{4'd12, 4'd0, 4'd4, 4'd5};
        logic ld[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        logic en[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic cl[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        exp_t want[4] = '{{4'd9, 1'b1, 1'b0, 1'b0, 1'b1},
                          {4'd9, 1'b1, 1'b0, 1'b0, 1'b0},
                          {4'd4, 1'b0, 1'b0, 1'b0, 1'b0},
                          {4'd0, 1'b0, 1'b0, 1'b0, 1'b0}};
        up = 1'b1; one_shot = 1'b0;
        for (int k = 0; k < 4; k++) begin
            load = ld[k]; load_value = lv[k]; enable = en[k]; clear = cl[k];
            expQ.push_back(want[k]);
            @(posedge clock); #1;
            got = {count, tc, wrap, done, load_err};
            e = expQ.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("[TB] FAIL %s: got {count,tc,wrap,done,err}=%b want %b", nm[k], got, e);
            end
        end
        load = 1'b0; enable = 1'b0; clear = 1'b0;
    endtask

    task automatic test_async_reset();
        up = 1'b1;
        load = 1'b1; load_value = 4'd6;
        expQ.push_back({4'd6, 1'b0, 1'b0, 1'b0, 1'b0});
        @(posedge clock); #1;
        got = {count, tc, wrap, done, load_err};
        e = expQ.pop_front();
        checks++;
        if (got !== e) begin
            errors++;
            $display("[TB] FAIL ares_load6: got {count,tc,wrap,done,err}=%b want %b", got, e);
        end
        load = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({count, tc, wrap, done, load_err} !== 8'b0000_0000) begin
            errors++;
            $display("[TB] FAIL ares_midcycle: got {count,tc,wrap,done,err}=%b want 00000000",
                     {count, tc, wrap, done, load_err});
        end
        @(negedge clock);
        reset_n = 1'b1;
        enable = 1'b1;
        expQ.push_back({4'd1, 1'b0, 1'b0, 1'b0, 1'b0});
        @(posedge clock); #1;
        got = {count, tc, wrap, done, load_err};
        e = expQ.pop_front();
        checks++;
        if (got !== e) begin
            errors++;
            $display("[TB] FAIL ares_resume: got {count,tc,wrap,done,err}=%b want %b", got, e);
        end
        enable = 1'b0;
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_count_down();
        test_one_shot();
        test_load_err();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sync_updown_counter.md
SYNC_UPDOWN_COUNTER -- requirements
Module: sync_updown_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 4: counter width in bits, legal 1..32.
REQ-002 SHALL have parameter MODULUS, default 2**WIDTH: count range 0..MODULUS-1, legal 2..2**WIDTH.
REQ-003 SHALL have port: clock  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port: reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port: clear  input  1  synchronous clear to 0.
REQ-006 SHALL have port: load  input  1  synchronous load of load_value.
REQ-007 SHALL have port: load_value  input  WIDTH  value to load.
REQ-008 SHALL have port: enable  input  1  count-step qualifier.
REQ-009 SHALL have port: up  input  1  direction: 1 = up, 0 = down.
REQ-010 SHALL have port: one_shot  input  1  1 = stop at terminal, 0 = free-run with wrap.
REQ-011 SHALL have port: count  output  WIDTH  registered count value.
REQ-012 SHALL have port: tc  output  1  combinational terminal-count flag.
REQ-013 SHALL have port: wrap  output  1  registered one-cycle wrap pulse.
REQ-014 SHALL have port: done  output  1  registered one-shot completion flag.
REQ-015 SHALL have port: load_err  output  1  registered one-cycle out-of-range-load pulse.

Function
REQ-016 SHALL be fully synchronous to clock: no output or internal signal used as a clock.
REQ-017 SHALL apply per-cycle priority clear > load > enable-step > hold.
REQ-018 SHALL, on clear, set count=0 and done=0.
REQ-019 SHALL, on load with load_value < MODULUS, set count=load_value and done=0.
REQ-020 SHALL, on load with load_value >= MODULUS, set count=MODULUS-1 and done=0, and pulse load_err high for exactly the next cycle.
REQ-021 SHALL, on an enabled step, apply up=1: count+1 and up=0: count-1.
REQ-022 SHALL assert tc while (up=1 and count=MODULUS-1) or (up=0 and count=0); tc follows up with no latency.
REQ-023 SHALL, when one_shot=0 and an enabled step occurs with tc=1, wrap count (up: to 0; down: to MODULUS-1) and set wrap=1 for the following cycle only.
REQ-024 SHALL, when one_shot=1 and an enabled step occurs with tc=1, hold count, set done=1, and never assert wrap.
REQ-025 SHALL hold done=1 until clear, load or reset; while done=1 and one_shot=1, enabled steps SHALL NOT change count.
REQ-026 SHALL, if one_shot deasserts while done=1, keep done=1 and resume counting on the next enabled step.
REQ-027 SHALL allow up to change on any cycle; a direction change takes effect on the next step with no latency.
REQ-028 SHALL perform all arithmetic in WIDTH+1 bits internally; count SHALL never hold a value >= MODULUS.
REQ-029 SHALL make clear or load override a simultaneous step, with no wrap pulse that cycle.

Reset
REQ-030 SHALL, while reset_n=0, immediately force count=0, wrap=0, done=0, load_err=0, independent of clock.
REQ-031 SHALL give tc after reset as 1 if up=0, else (MODULUS-1=0 impossible) 0.
REQ-032 SHALL resume normal operation on the first rising clock edge after reset_n deasserts; reset mid-count SHALL discard all in-flight state.

Structure
REQ-033 SHALL take direction constants (DIR_UP=1, DIR_DOWN=0) and the WIDTH/MODULUS legality-check function from shared package counter_pkg.
REQ-034 SHALL isolate next-value and wrap/terminal computation in one combinational sub-module, updown_next_value; registers SHALL live in the top.
REQ-035 SHALL fail elaboration when MODULUS < 2 or MODULUS > 2**WIDTH.

Verification (WIDTH=4, MODULUS=10)
REQ-036 SHALL cover: reset, up=1, enable=1, one_shot=0 for 12 cycles -> count 0..9,0,1; wrap high exactly the cycle after 9->0.
REQ-037 SHALL cover: load 3, up=0, 5 steps -> count 2,1,0,9,8; tc high at 0; wrap pulse after 0->9.
REQ-038 SHALL cover: one_shot=1, load 7, up=1, 4 steps -> count 8,9,9,9; done=1 from the step at 9 onward; no wrap pulse.
REQ-039 SHALL cover: load_value=12 -> count=9, load_err pulses 1 cycle; then load, clear and step in the same cycle -> count=0.
REQ-040 SHALL cover: reset_n low between clock edges at count=6 -> count=0 asynchronously, done/wrap/load_err=0.
